// File: rtl/spectrum_collector.sv
// Collects streamed FFT bins into parallel real/imag arrays, hands a frame-aligned
// mask to the downstream filter and waits (with a watchdog) for it to finish.
module spectrum_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  parameter int TIMEOUT    = 255,
  parameter int IDX_W      = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         in_last,
  input  logic [0:N-1]                 mask_in,
  input  logic                         mask_load,
  output logic signed [DATA_WIDTH-1:0] real_bus [0:N-1],
  output logic signed [DATA_WIDTH-1:0] imag_bus [0:N-1],
  output logic [0:N-1]                 mask_out,
  output logic                         start_filter,
  input  logic                         filter_done,
  output logic                         frame_err,
  output logic [15:0]                  frame_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] wr_ptr;
  logic [0:N-1]     mask_shadow;
  logic [WD_W-1:0]  watchdog;
  logic             accept;
  logic             frame_end;

  assign in_ready  = (state == FILL) && !reset;
  assign accept    = in_valid && in_ready;
  assign frame_end = in_last || (wr_ptr == IDX_W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      wr_ptr       <= '0;
      mask_out     <= '1;
      mask_shadow  <= '1;
      start_filter <= 1'b0;
      frame_err    <= 1'b0;
      frame_count  <= '0;
      watchdog     <= '0;
      // NOTE: the bin arrays drive the filter directly, so they are reset like
      // any other output register instead of being left as uninitialised storage.
      for (int i = 0; i < N; i++) begin
        real_bus[i] <= '0;
        imag_bus[i] <= '0;
      end
    end else begin
      start_filter <= 1'b0;
      frame_err    <= 1'b0;
      if (mask_load) mask_shadow <= mask_in;

      case (state)
        FILL: begin
          if (accept) begin
            // An early last bin also clears the tail so stale bins never reach the filter.
            for (int i = 0; i < N; i++) begin
              if (i == int'(wr_ptr)) begin
                real_bus[i] <= in_real;
                imag_bus[i] <= in_imag;
              end else if (in_last && i > int'(wr_ptr)) begin
                real_bus[i] <= '0;
                imag_bus[i] <= '0;
              end
            end
            wr_ptr <= wr_ptr + 1'b1;
            if (frame_end) begin
              state        <= ISSUE;
              start_filter <= 1'b1;
              mask_out     <= mask_shadow;
              frame_count  <= frame_count + 16'd1;
              watchdog     <= '0;
              frame_err    <= !(in_last && wr_ptr == IDX_W'(N - 1));
            end
          end
        end

        // The watchdog counts cycles since start_filter, so the ISSUE cycle is the first.
        ISSUE: begin
          state    <= WAIT;
          wr_ptr   <= '0;
          watchdog <= WD_W'(1);
        end

        WAIT: begin
          if (filter_done) begin
            state  <= FILL;
            wr_ptr <= '0;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            state     <= FILL;
            wr_ptr    <= '0;
            frame_err <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_collector.sv
// Directed bench for spectrum_collector: a frame-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_spectrum_collector;

  localparam int DW      = 16;
  localparam int N       = 16;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_imag = '0;
  logic                 in_last = 1'b0;
  logic [0:N-1]         mask_in = '0;
  logic                 mask_load = 1'b0;
  logic signed [DW-1:0] real_bus [0:N-1];
  logic signed [DW-1:0] imag_bus [0:N-1];
  logic [0:N-1]         mask_out;
  logic                 start_filter;
  logic                 filter_done = 1'b0;
  logic                 frame_err;
  logic [15:0]          frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  spectrum_collector #(.DATA_WIDTH(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .mask_in(mask_in), .mask_load(mask_load),
    .real_bus(real_bus), .imag_bus(imag_bus), .mask_out(mask_out),
    .start_filter(start_filter), .filter_done(filter_done),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Tracks frames as "bins collected so far" and "cycles since start_filter".
  typedef enum {M_COLLECT, M_HANDOFF, M_AWAIT} mphase_t;
  mphase_t              m_phase;
  int                   m_collected;
  int                   m_since_start;
  logic signed [DW-1:0] m_real [0:N-1];
  logic signed [DW-1:0] m_imag [0:N-1];
  logic [0:N-1]         m_shadow, m_mask;
  logic                 m_start, m_err;
  logic [15:0]          m_count;

  always @(posedge clk or posedge reset) begin
    logic [0:N-1] prev_shadow;
    if (reset) begin
      m_phase = M_COLLECT; m_collected = 0; m_since_start = 0;
      m_shadow = '1; m_mask = '1; m_start = 0; m_err = 0; m_count = 0;
      for (int i = 0; i < N; i++) begin m_real[i] = 0; m_imag[i] = 0; end
    end else begin
      prev_shadow = m_shadow;
      if (mask_load) m_shadow = mask_in;
      m_start = 0;
      m_err   = 0;
      if (m_phase == M_COLLECT) begin
        if (in_valid) begin
          m_real[m_collected] = in_real;
          m_imag[m_collected] = in_imag;
          m_collected++;
          if (in_last || m_collected == N) begin
            if (in_last)
              for (int i = m_collected; i < N; i++) begin m_real[i] = 0; m_imag[i] = 0; end
            m_err         = !(in_last && m_collected == N);
            m_start       = 1;
            m_mask        = prev_shadow;
            m_count       = m_count + 1;
            m_since_start = 0;
            m_collected   = 0;
            m_phase       = M_HANDOFF;
          end
        end
      end else begin
        m_since_start++;
        if (m_phase == M_HANDOFF) m_phase = M_AWAIT;
        else if (filter_done) m_phase = M_COLLECT;
        else if (m_since_start == TIMEOUT) begin
          m_err   = 1;
          m_phase = M_COLLECT;
        end
      end
    end
  end

  // Single compare process, outputs sampled mid-cycle.
  always @(negedge clk) begin
    int bad_r, bad_i;
    bad_r = 0; bad_i = 0;
    for (int i = 0; i < N; i++) begin
      if (real_bus[i] !== m_real[i]) bad_r++;
      if (imag_bus[i] !== m_imag[i]) bad_i++;
    end
    check("in_ready", in_ready, (m_phase == M_COLLECT) && !reset);
    check("start_filter", start_filter, m_start);
    check("frame_err", frame_err, m_err);
    check("frame_count", frame_count, m_count);
    check("mask_out", mask_out, m_mask);
    check("real_bus_bad_entries", bad_r, 0);
    check("imag_bus_bad_entries", bad_i, 0);
  end

  // ---------------- stimulus ----------------
  task automatic send_bin(input int re, input int im, input logic last, input bit stall);
    if (stall) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_real = DW'(re); in_imag = DW'(im); in_last = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_bin_accept_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (start_filter) return;
    end
    check({name, "_start_timeout"}, 0, 1);
  endtask

  // Called at the negedge of the ISSUE cycle; done pulses two cycles later.
  task automatic done_after_two;
    @(posedge clk); #1;
    @(posedge clk); #1;
    filter_done = 1'b1;
    @(posedge clk); #1;
    filter_done = 1'b0;
  endtask

  initial begin
    int k;
    mask_in = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_mask_out", mask_out, 16'hFFFF);
    reset = 1'b0;

    // 1: clean frame, no stalls
    for (int b = 0; b < N; b++) send_bin(b, -b, b == N - 1, 0);
    wait_start("t1");
    check("t1_real5", real_bus[5], 5);
    check("t1_imag5", imag_bus[5], -5);
    check("t1_err", frame_err, 0);
    check("t1_count", frame_count, 1);
    done_after_two();

    // 2: same frame with random valid gaps
    for (int b = 0; b < N; b++) send_bin(b, -b, b == N - 1, $urandom_range(0, 1) == 1);
    wait_start("t2");
    check("t2_real15", real_bus[15], 15);
    check("t2_imag15", imag_bus[15], -15);
    check("t2_count", frame_count, 2);
    done_after_two();

    // 3: early last on bin 9
    for (int b = 0; b < 10; b++) send_bin(100 + b, -(100 + b), b == 9, 0);
    wait_start("t3");
    check("t3_err", frame_err, 1);
    check("t3_real9", real_bus[9], 109);
    check("t3_real12", real_bus[12], 0);
    check("t3_imag15", imag_bus[15], 0);
    done_after_two();

    // 4: missing last, then timeout with a mask load during WAIT
    for (int b = 0; b < N; b++) send_bin(200 + b, 200 + b, 0, 0);
    wait_start("t4");
    check("t4_err_at_issue", frame_err, 1);
    k = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      k++;
      if (k == 1) begin mask_in = 16'h00FF; mask_load = 1'b1; end
      if (k == 2) mask_load = 1'b0;
      if (frame_err) break;
      check("t4_mask_held", mask_out, 16'hFFFF);
    end
    check("t4_timeout_cycles", k, 8);
    check("t4_ready_after_timeout", in_ready, 1);
    @(posedge clk); #1;
    for (int b = 0; b < N; b++) send_bin(b, b, b == N - 1, 0);
    wait_start("t4b");
    check("t4_mask_new", mask_out, 16'h00FF);
    check("t4_count", frame_count, 5);
    done_after_two();

    // 5: reset mid-frame
    for (int b = 0; b < 8; b++) send_bin(50 + b, 50 + b, 0, 0);
    reset = 1'b1;
    #1;
    check("t5_ready", in_ready, 0);
    check("t5_count", frame_count, 0);
    check("t5_real3", real_bus[3], 0);
    check("t5_mask", mask_out, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int b = 0; b < N; b++) send_bin(300 + b, -b, b == N - 1, 0);
    wait_start("t5");
    check("t5_count_after", frame_count, 1);
    check("t5_real0", real_bus[0], 300);
    done_after_two();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spectrum_collector.md
Name: spectrum_collector

Overview:
Upstream stage of freq_filter. Accepts FFT output bins streamed one per cycle over a valid/ready handshake and assembles them into N-entry parallel real/imag arrays. Latches a frame-aligned mask and issues a one-cycle start_filter pulse. Holds the arrays stable until filter_done returns, with a watchdog timeout and frame-alignment error reporting.

Parameters:
DATA_WIDTH, 16, bit width of each real/imag sample
N, 16, bins per frame; power of 2, >= 2
TIMEOUT, 255, max cycles to wait for filter_done after start_filter before abort; >= 2
IDX_W, $clog2(N), write-pointer width (derived)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream bin valid
in_ready  output  1  block can accept a bin this cycle
in_real  input  DATA_WIDTH signed  real part of streamed bin
in_imag  input  DATA_WIDTH signed  imag part of streamed bin
in_last  input  1  marks final bin of upstream frame
mask_in  input  [0:N-1]  new mask value (1 = keep)
mask_load  input  1  capture mask_in into shadow register
real_bus  output  DATA_WIDTH signed x [0:N-1]  parallel real bins to filter
imag_bus  output  DATA_WIDTH signed x [0:N-1]  parallel imag bins to filter
mask_out  output  [0:N-1]  frame mask to filter
start_filter  output  1  one-cycle pulse, arrays valid
filter_done  input  1  filter completion pulse
frame_err  output  1  one-cycle pulse on alignment error or timeout
frame_count  output  16  issued frames, wraps at 65535 -> 0

Behaviour:
- Reset, asynchronous: state=FILL, wr_ptr=0, all real_bus/imag_bus entries=0, mask_out=all 1s, mask shadow=all 1s, start_filter=0, frame_err=0, frame_count=0, watchdog=0.
- in_ready is 1 only in FILL; it is 0 while reset is asserted.
- Handshake: a bin is accepted on a rising edge where in_valid && in_ready. Bin data is written to index wr_ptr; wr_ptr increments.
- States:
  - FILL: accept bins.
    - Accept at wr_ptr==N-1: go to ISSUE. If in_last=0 on that bin, pulse frame_err.
    - Accept with in_last=1 at wr_ptr<N-1 (early last): write the bin, zero every entry with index > wr_ptr in the same edge, pulse frame_err, go to ISSUE.
  - ISSUE: single cycle.
    - start_filter=1 (registered output, high for exactly this cycle). mask_out <= shadow. frame_count += 1. watchdog cleared. Go to WAIT.
  - WAIT: in_ready=0, arrays frozen.
    - filter_done=1: go to FILL, wr_ptr=0.
    - Else watchdog += 1. On watchdog reaching TIMEOUT: pulse frame_err, go to FILL, wr_ptr=0.
- filter_done seen outside WAIT is ignored.
- Shadow mask captures mask_in on any edge with mask_load=1, in any state. mask_out changes only on entry to ISSUE, so the mask stays frame-aligned.
- real_bus, imag_bus and mask_out are constant from the ISSUE cycle until the next FILL write.
- In FILL, entries not yet overwritten keep previous-frame values until written.
- Latency: last bin accepted at edge k -> start_filter high in cycle k+1 -> earliest next bin accepted at edge after filter_done is sampled.
- Simultaneous events:
  - mask_load in the ISSUE cycle: the shadow updates, but mask_out takes the old shadow value; the new value applies next frame.
  - filter_done on the same edge as watchdog==TIMEOUT: done wins, no frame_err.
- frame_err is registered, one cycle wide; at most one pulse per frame, except that a timeout may add one more.
- Reset mid-frame: all partial data is discarded and the block returns to the reset values above.

Test Plan:
- N=16, stream bins k=0..15 with real=k, imag=-k, in_last on bin 15, no stalls. Required: start_filter one cycle after bin 15; real_bus[5]=5, imag_bus[5]=-5; frame_err=0; frame_count=1.
- Drop in_valid randomly during fill and respond with filter_done 2 cycles after start_filter. Required: identical arrays; in_ready=0 from ISSUE until the cycle after done; the second frame is accepted.
- Send in_last on bin 9 (values 100..109). Required: entries 0..9 = 100..109, entries 10..15 = 0, frame_err one pulse, start_filter issued.
- Send 16 bins with no in_last. Required: frame_err pulse coinciding with ISSUE; the frame is still issued.
- Hold filter_done=0 with TIMEOUT=8. Required: frame_err 8 cycles after start_filter, then in_ready=1. Separately, mask_load=0x00FF during WAIT: mask_out stays 0xFFFF until the next ISSUE, then becomes 0x00FF.
- Assert reset after bin 7. Required: all outputs return to reset values immediately; the next full frame issues with frame_count=1.
